// File: rtl/prefix_pkg.sv
// Shared prefix-symbol definitions used by the append stages and the packer.
package prefix_pkg;
   localparam int SYM_W = 2;

   typedef logic [SYM_W-1:0] sym_t;

   localparam sym_t PFX_10 = 2'b10;
   localparam sym_t PFX_11 = 2'b11;
endpackage

// File: rtl/prefix_packer.sv
// Packs 2-bit prefix symbols MSB-first into WORD_W-bit words, flushing on a
// full word or on in_last, behind a registered output stage.
module prefix_packer
   import prefix_pkg::*;
#(
   parameter int WORD_W = 16
) (
   input  logic                        clk,
   input  logic                        rst_n,
   input  logic                        in_valid,
   output logic                        in_ready,
   input  sym_t                        in_sym,
   input  logic                        in_last,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [WORD_W-1:0]           out_word,
   output logic [$clog2(WORD_W):0]     out_bits
);

   localparam int SYMS   = WORD_W / 2;
   localparam int CNT_W  = $clog2(SYMS);
   localparam int BITS_W = $clog2(WORD_W) + 1;

   // Handshakes: a transfer happens on a rising edge where valid && ready;
   // valid never waits on ready, and in_ready never looks at in_valid.

   // Only SYMS-1 symbols ever sit in the accumulator: the symbol that fills
   // the lowest pair always completes the word and goes straight to out_word.
   logic [WORD_W-3:0] acc;
   logic [CNT_W-1:0]  cnt;
   logic [WORD_W-1:0] post;
   logic [BITS_W-1:0] bits_next;
   logic              complete;
   logic              pending;
   logic              accept;

   assign post      = {in_sym, acc};
   assign bits_next = (BITS_W'(cnt) + BITS_W'(1)) << 1;
   assign accept    = in_valid && in_ready;

   always_comb begin
      complete = (cnt == CNT_W'(SYMS - 1)) || in_last;
      pending  = out_valid && !out_ready;
      in_ready = !pending || !complete;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         acc <= '0;
         cnt <= '0;
      end else if (accept) begin
         if (complete) begin
            acc <= '0;
            cnt <= '0;
         end else begin
            acc <= post[WORD_W-1:2];
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // A load wins over a drain, giving back-to-back words with no bubble.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_word  <= '0;
         out_bits  <= '0;
      end else if (accept && complete) begin
         out_valid <= 1'b1;
         out_word  <= post;
         out_bits  <= bits_next;
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_prefix_packer.sv
// Directed bench for prefix_packer at WORD_W = 8: vector table plus
// hand-written reset, backpressure and back-to-back sequences.
module tb_prefix_packer;
   import prefix_pkg::*;

   localparam int W  = 8;
   localparam int BW = 4;

   logic          clk;
   logic          rst_n;
   logic          in_valid;
   logic          in_ready;
   sym_t          in_sym;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_word;
   logic [BW-1:0] out_bits;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   logic [W+BW-1:0] exp_q[$];
   int              xfer_q[$];

   typedef struct {
      sym_t          sym;
      logic          last;
      logic          exp_valid;
      logic [W-1:0]  exp_word;
      logic [BW-1:0] exp_bits;
   } vec_t;

   vec_t vecs[11];

   prefix_packer #(.WORD_W(W)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_sym    (in_sym),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_word  (out_word),
      .out_bits  (out_bits)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, act=running req=finished");
      $fatal(1);
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: act=%0h req=%0h (t=%0t)", name, act, req, $time);
      end
   endtask

   // driver: present one symbol and hold it until accepted (bounded)
   task automatic send(input sym_t s, input logic l, output int waits);
      waits    = 0;
      in_valid = 1'b1;
      in_sym   = s;
      in_last  = l;
      @(negedge clk);
      while (!in_ready && waits < 50) begin
         @(negedge clk);
         waits++;
      end
      if (!in_ready) check("send_timeout", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // scoreboard: a transfer happens at the next rising edge when this holds
   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         xfer_q.push_back(cyc);
         if (exp_q.size() == 0) begin
            check("unexpected_word", 32'({out_word, out_bits}), 32'hFFFF_FFFF);
         end else begin
            check("sb_word_bits", 32'({out_word, out_bits}), 32'(exp_q.pop_front()));
         end
      end
   end

   initial begin
      int w;
      int stalls;
      int n;

      vecs[0]  = '{PFX_10, 1'b0, 1'b0, 8'h00, 4'd0};
      vecs[1]  = '{PFX_11, 1'b0, 1'b0, 8'h00, 4'd0};
      vecs[2]  = '{PFX_10, 1'b0, 1'b0, 8'h00, 4'd0};
      vecs[3]  = '{PFX_11, 1'b0, 1'b1, 8'hEE, 4'd8};
      vecs[4]  = '{PFX_10, 1'b0, 1'b0, 8'h00, 4'd0};
      vecs[5]  = '{PFX_11, 1'b1, 1'b1, 8'hE0, 4'd4};
      vecs[6]  = '{PFX_11, 1'b1, 1'b1, 8'hC0, 4'd2};
      vecs[7]  = '{PFX_10, 1'b1, 1'b1, 8'h80, 4'd2};
      vecs[8]  = '{2'b01,  1'b0, 1'b0, 8'h00, 4'd0};
      vecs[9]  = '{2'b00,  1'b0, 1'b0, 8'h00, 4'd0};
      vecs[10] = '{PFX_10, 1'b1, 1'b1, 8'h84, 4'd6};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_sym    = '0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_word",  32'(out_word),  32'd0);
      check("rst_out_bits",  32'(out_bits),  32'd0);
      check("rst_in_ready",  32'(in_ready),  32'd1);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // table: full word, early flush, single-symbol codes, mixed symbols
      for (int i = 0; i < 11; i++) begin
         if (vecs[i].exp_valid) exp_q.push_back({vecs[i].exp_word, vecs[i].exp_bits});
         send(vecs[i].sym, vecs[i].last, w);
         check($sformatf("vec%0d_stall", i), 32'(w), 32'd0);
         check($sformatf("vec%0d_out_valid", i), 32'(out_valid), 32'(vecs[i].exp_valid));
         if (vecs[i].exp_valid) begin
            check($sformatf("vec%0d_out_word", i), 32'(out_word), 32'(vecs[i].exp_word));
            check($sformatf("vec%0d_out_bits", i), 32'(out_bits), 32'(vecs[i].exp_bits));
         end
      end
      repeat (2) @(posedge clk);
      #1;
      check("table_drained", 32'(exp_q.size()), 32'd0);

      // backpressure: first word held, three more accepted, fourth stalls
      out_ready = 1'b0;
      exp_q.push_back({8'hFF, 4'd8});
      exp_q.push_back({8'hFF, 4'd8});
      for (int i = 0; i < 4; i++) send(PFX_11, 1'b0, w);
      check("bp_word1_valid", 32'(out_valid), 32'd1);
      check("bp_word1_word",  32'(out_word),  32'hFF);
      for (int i = 0; i < 3; i++) begin
         send(PFX_11, 1'b0, w);
         check("bp_nc_accept_stall", 32'(w), 32'd0);
         check("bp_word1_hold", 32'({out_valid, out_word}), 32'h1FF);
      end
      in_valid = 1'b1;
      in_sym   = PFX_11;
      in_last  = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("bp_in_ready_low", 32'(in_ready), 32'd0);
         check("bp_word1_stable", 32'({out_valid, out_word, out_bits}), 32'h1FF8);
      end
      @(posedge clk);
      #1;
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_in_ready_high", 32'(in_ready), 32'd1);
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      check("bp_no_bubble_valid", 32'(out_valid), 32'd1);
      check("bp_word2", 32'({out_word, out_bits}), 32'hFF8);
      repeat (2) @(posedge clk);
      #1;
      n = xfer_q.size();
      check("bp_drained", 32'(exp_q.size()), 32'd0);
      check("bp_consecutive", 32'(xfer_q[n-1] - xfer_q[n-2]), 32'd1);

      // back-to-back: 12 symbols, three words on 4-cycle boundaries
      stalls = 0;
      for (int i = 0; i < 12; i++) begin
         sym_t s;
         s = (i % 2 == 0) ? PFX_10 : PFX_11;
         if (i % 4 == 3) exp_q.push_back({8'hEE, 4'd8});
         send(s, 1'b0, w);
         stalls += w;
      end
      repeat (2) @(posedge clk);
      #1;
      n = xfer_q.size();
      check("b2b_stalls", 32'(stalls), 32'd0);
      check("b2b_drained", 32'(exp_q.size()), 32'd0);
      check("b2b_gap1", 32'(xfer_q[n-2] - xfer_q[n-3]), 32'd4);
      check("b2b_gap2", 32'(xfer_q[n-1] - xfer_q[n-2]), 32'd4);

      // reset mid-operation discards held word and partial accumulator
      out_ready = 1'b0;
      for (int i = 0; i < 4; i++) send(PFX_10, 1'b0, w);
      send(PFX_10, 1'b0, w);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_out_valid", 32'(out_valid), 32'd0);
      check("mid_rst_out_word",  32'(out_word),  32'd0);
      check("mid_rst_out_bits",  32'(out_bits),  32'd0);
      check("mid_rst_in_ready",  32'(in_ready),  32'd1);
      @(posedge clk);
      #1;
      rst_n     = 1'b1;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      exp_q.push_back({8'hC0, 4'd2});
      send(PFX_11, 1'b1, w);
      check("post_rst_word", 32'({out_valid, out_word, out_bits}), 32'h1C02);
      repeat (2) @(posedge clk);
      #1;
      check("final_drained", 32'(exp_q.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/prefix_packer.md
# prefix_packer

Downstream packing stage for the 2-bit prefix symbols (`10`, `11`, …) produced by the append stages. It accepts one 2-bit symbol per cycle over a valid/ready handshake. Each new symbol is prepended on the MSB side of an accumulator. A packed word is emitted when the word is full, or early when the producer marks the last symbol of a code. A registered output stage lets packing overlap with a stalled consumer.

## Interface
- `WORD_W`, default 16: packed word width in bits. Must be even and ≥ 4.
- `SYMS`, derived as `WORD_W/2`: number of symbols per full word. Not overridable.
- `clk`, input, 1: single clock; all state changes on the rising edge.
- `rst_n`, input, 1: reset, asynchronous and active-low.
- `in_valid`, input, 1: `in_sym` and `in_last` are valid this cycle.
- `in_ready`, output, 1: the symbol is accepted when `in_valid && in_ready` at the rising edge.
- `in_sym`, input, 2: prefix symbol.
- `in_last`, input, 1: this symbol ends the current code; flush after accepting it.
- `out_valid`, output, 1: `out_word` and `out_bits` are valid.
- `out_ready`, input, 1: the consumer takes the word when `out_valid && out_ready`.
- `out_word`, output, `WORD_W`: packed word.
- `out_bits`, output, `$clog2(WORD_W)+1`: number of valid bits, MSB-aligned. Always even, in the range 2 to `WORD_W`.

## Operation
- Accumulator `acc[WORD_W-1:0]` and symbol count `cnt` (range 0 to `SYMS-1`).
- Accepted symbol updates: `acc <= {in_sym, acc[WORD_W-1:2]}`, `cnt <= cnt+1`.
- After k symbols, valid bits are `acc[WORD_W-1 : WORD_W-2k]`. The first symbol is in the lowest valid pair; the newest symbol is in `[WORD_W-1:WORD_W-2]`.
- `complete = (cnt == SYMS-1) || in_last`, evaluated on the accepted symbol.
- On an accept with `complete`:
  - `out_word` is loaded with the post-shift accumulator value; unused LSBs are zero.
  - `out_bits` is loaded with `2*(cnt+1)`.
  - `out_valid` is set to 1.
  - `acc` and `cnt` are cleared to 0.
- `pending = out_valid && !out_ready`.
- `in_ready = !pending || !complete`:
  - Non-completing symbols are always accepted.
  - A completing symbol stalls only while the output register is occupied and not draining.
  - `in_ready` may depend combinationally on `in_last`, `cnt`, `out_valid` and `out_ready`. It must not depend on `in_valid`.
- Output register:
  - `out_valid` clears on `out_valid && out_ready` unless a new word loads in the same cycle.
  - A simultaneous drain and load is a back-to-back word with no bubble.
  - `out_word` and `out_bits` are held stable while `pending`.
- `in_last` on the first symbol emits a 2-bit word: `out_bits = 2`, word `{sym, zeros}`.
- There is no empty flush. `in_last` always carries a symbol.
- Reset mid-word discards the partial accumulator and any held output word. No word is emitted for them.

## Timing
- Reset values:
  - `out_valid = 0`, `out_word = 0`, `out_bits = 0`.
  - `acc = 0`, `cnt = 0`.
  - `in_ready = 1`, derived combinationally from the reset state.
- Latency: `out_valid` rises one cycle after the completing symbol is accepted.
- Throughput: one symbol per cycle sustained while `out_ready` is held high.
- There is no ready-to-valid combinational path on the output side. `out_*` are pure registers.

## Structure
- Shared package `prefix_pkg`:
  - `SYM_W = 2`.
  - Symbol constants `PFX_10 = 2'b10` and `PFX_11 = 2'b11`.
  - Typedef `sym_t`.
  - The append stages reuse the same constants.
- Single module; no sub-module is needed.
  - Accumulator and output register are two `always_ff` blocks.
  - `in_ready` and `complete` are one `always_comb` block.

## Test plan
The bench uses `WORD_W = 8` (`SYMS = 4`).
- Reset: assert `rst_n = 0` mid-operation -> `out_valid = 0`, `out_word = 0`, `in_ready = 1` immediately; the next word starts from an empty accumulator.
- Full word: symbols `10,11,10,11` with `out_ready = 1` -> `out_word = 8'hEE`, `out_bits = 8`, one cycle after the 4th accept.
- Early flush: `10`, then `11` with `in_last` -> `out_word = 8'hE0`, `out_bits = 4`; `cnt` returns to 0.
- Backpressure: `out_ready = 0`, stream 8 symbols of `11` -> first word `8'hFF` held stable; 3 more symbols are accepted; `in_ready` drops at the 4th. Raise `out_ready` -> second word `8'hFF` follows with no bubble.
- Back-to-back: 12 symbols continuous with `out_ready = 1` -> 3 words on consecutive 4-cycle boundaries; `in_ready` never drops.
- Single-symbol code: `11` with `in_last` on the first symbol -> `out_word = 8'hC0`, `out_bits = 2`.
